// File: rtl/leb128_decoder_if.sv
// rtl/leb128_decoder_if.sv - encoded byte stream handshake between fetch and the LEB128 decoder
//
// Purpose: carries one encoded immediate byte per transfer.
// A transfer occurs on a clock edge where byte_valid and byte_ready are both high.
//
// Signals:
//   byte_in    - encoded byte from fetch (master -> slave)
//   byte_valid - byte_in is valid (master -> slave)
//   byte_ready - decoder accepts a byte this cycle (slave -> master)
interface leb128_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/leb128_decoder.sv
// rtl/leb128_decoder.sv - signed/unsigned 32/64-bit LEB128 immediate decoder
//
// Purpose: consumes the instruction byte stream and decodes one LEB128 immediate.
// The decoded immediate is returned as a 64-bit operand.
// Malformed encodings produce a trap code.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - begin a decode (honoured in IDLE or ERROR only)
//   signed_mode  - 1 = sLEB128, latched on start
//   width64      - 1 = 64-bit limits, 0 = 32-bit limits, latched on start
//   bus          - byte stream slave (byte_in / byte_valid / byte_ready)
//   value        - decoded immediate; 32-bit results are sign- or zero-extended
//   done         - one-cycle pulse; value is valid
//   busy         - decode in progress
//   trap         - 0 none, 1 LEB_TOO_LONG, 2 LEB_OVERFLOW
module leb128_decoder #(
  parameter int MAX_BYTES64 = 10,
  parameter int MAX_BYTES32 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   width64,
  leb128_decoder_if.slave        bus,
  output logic [63:0]            value,
  output logic                   done,
  output logic                   busy,
  output logic [3:0]             trap
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERROR} state_t;

  state_t      state, state_next;
  logic [63:0] acc;
  logic [6:0]  shift;
  logic [3:0]  count;
  logic        sm;
  logic        w64;

  logic        byte_ready_c;
  logic        load_start;
  logic        load_value;
  logic        set_trap;
  logic [3:0]  trap_code;

  logic        xfer;
  logic [3:0]  limit;
  logic [3:0]  count_inc;
  logic        last;
  logic        last_ok;
  logic [6:0]  new_shift;
  logic [63:0] acc_next;
  logic [63:0] ext;
  logic [63:0] final_value;

  assign bus.byte_ready = byte_ready_c;

  assign xfer      = (state == ACCUM) && bus.byte_valid;
  assign limit     = w64 ? 4'(MAX_BYTES64) : 4'(MAX_BYTES32);
  assign count_inc = count + 4'd1;
  assign last      = (count_inc == limit);
  assign new_shift = shift + 7'd7;
  // At byte 10 the shift is 63, so payload bits above bit 63 fall off here.
  assign acc_next  = acc | ({57'd0, bus.byte_in[6:0]} << shift);

  // The final byte at the length limit may only carry bits that fit the
  // target width (unsigned) or that replicate the sign (signed).
  always_comb begin
    last_ok = 1'b1;
    case ({w64, sm})
      2'b00: last_ok = (bus.byte_in[6:4] == 3'd0);
      2'b01: last_ok = (&bus.byte_in[6:3]) || (bus.byte_in[6:3] == 4'd0);
      2'b10: last_ok = (bus.byte_in[6:1] == 6'd0);
      2'b11: last_ok = (bus.byte_in[6:0] == 7'h00) || (bus.byte_in[6:0] == 7'h7F);
      default: last_ok = 1'b1;
    endcase
  end

  // Sign fill from the first unwritten bit, then narrow to 32 bits if needed.
  always_comb begin
    ext = acc_next;
    if (sm && bus.byte_in[6] && (new_shift < 7'd64)) begin
      ext = ext | (~64'd0 << new_shift);
    end
    if (w64) begin
      final_value = ext;
    end else if (sm) begin
      final_value = {{32{ext[31]}}, ext[31:0]};
    end else begin
      final_value = {32'd0, ext[31:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    byte_ready_c = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    load_start   = 1'b0;
    load_value   = 1'b0;
    set_trap     = 1'b0;
    trap_code    = 4'd0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        busy         = 1'b1;
        byte_ready_c = 1'b1;
        if (xfer) begin
          if (bus.byte_in[7]) begin
            if (last) begin
              set_trap   = 1'b1;
              trap_code  = 4'd1;
              state_next = ERROR;
            end
          end else if (last && !last_ok) begin
            set_trap   = 1'b1;
            trap_code  = 4'd2;
            state_next = ERROR;
          end else begin
            load_value = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        if (start) begin
          load_start = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= 64'd0;
      shift <= 7'd0;
      count <= 4'd0;
      sm    <= 1'b0;
      w64   <= 1'b0;
      value <= 64'd0;
      trap  <= 4'd0;
    end else begin
      if (load_start) begin
        acc   <= 64'd0;
        shift <= 7'd0;
        count <= 4'd0;
        sm    <= signed_mode;
        w64   <= width64;
        trap  <= 4'd0;
      end else if (xfer) begin
        acc   <= acc_next;
        shift <= new_shift;
        count <= count_inc;
      end
      if (set_trap) begin
        trap <= trap_code;
      end
      if (load_value) begin
        value <= final_value;
      end
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// tb/tb_leb128_decoder.sv - self-checking bench for leb128_decoder
module tb_leb128_decoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic        width64;
  logic [63:0] value;
  logic        done;
  logic        busy;
  logic [3:0]  trap;

  leb128_decoder_if bus ();

  leb128_decoder #(
    .MAX_BYTES64(10),
    .MAX_BYTES32(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .width64     (width64),
    .bus         (bus.slave),
    .value       (value),
    .done        (done),
    .busy        (busy),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bytes are packed with the first byte sent in b[7:0].
  typedef struct {
    logic        sgn;
    logic        w64;
    int          n;
    logic [79:0] b;
    logic        gap;
    logic [63:0] ev;
    logic [3:0]  et;
    logic        ed;
  } vec_t;

  vec_t vt [14];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic s, input logic w, input int n, input logic [79:0] b,
                              input logic g, input logic [63:0] ev, input logic [3:0] et,
                              input logic ed);
    vec_t v;
    v.sgn = s; v.w64 = w; v.n = n; v.b = b; v.gap = g; v.ev = ev; v.et = et; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic s, input logic w);
    start       = 1'b1;
    signed_mode = s;
    width64     = w;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic rdy_ok;
    logic [7:0] bt;
    do_start(v.sgn, v.w64);
    chk($sformatf("v%0d busy after start", idx), {63'd0, busy}, 64'd1);
    chk($sformatf("v%0d trap after start", idx), {60'd0, trap}, 64'd0);
    rdy_ok = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      if (!bus.byte_ready) rdy_ok = 1'b0;
      bt             = v.b[8*i +: 8];
      bus.byte_in    = bt;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      if (v.gap && (i < v.n - 1)) begin
        bus.byte_valid = 1'b0;
        if (!bus.byte_ready) rdy_ok = 1'b0;
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b0;
    chk($sformatf("v%0d byte_ready during decode", idx), {63'd0, rdy_ok}, 64'd1);
    chk($sformatf("v%0d done", idx), {63'd0, done}, {63'd0, v.ed});
    chk($sformatf("v%0d value", idx), value, v.ev);
    chk($sformatf("v%0d trap", idx), {60'd0, trap}, {60'd0, v.et});
    chk($sformatf("v%0d byte_ready after end", idx), {63'd0, bus.byte_ready}, 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d done one cycle", idx), {63'd0, done}, 64'd0);
    chk($sformatf("v%0d byte_ready idle", idx), {63'd0, bus.byte_ready}, 64'd0);
    chk($sformatf("v%0d trap hold", idx), {60'd0, trap}, {60'd0, v.et});
  endtask

  initial begin
    vt[0]  = mk(0, 1, 3,  80'h268EE5, 0, 64'h0000000000098765, 4'd0, 1);
    vt[1]  = mk(1, 1, 3,  80'h78BBC0, 1, 64'hFFFFFFFFFFFE1DC0, 4'd0, 1);
    vt[2]  = mk(1, 0, 1,  80'h7F, 0, 64'hFFFFFFFFFFFFFFFF, 4'd0, 1);
    vt[3]  = mk(0, 0, 1,  80'h7F, 0, 64'h000000000000007F, 4'd0, 1);
    vt[4]  = mk(0, 0, 5,  80'h0FFFFFFFFF, 0, 64'h00000000FFFFFFFF, 4'd0, 1);
    vt[5]  = mk(0, 0, 5,  80'h1FFFFFFFFF, 0, 64'h00000000FFFFFFFF, 4'd2, 0);
    vt[6]  = mk(0, 1, 10, 80'h80808080808080808080, 0, 64'h00000000FFFFFFFF, 4'd1, 0);
    vt[7]  = mk(0, 1, 1,  80'h05, 0, 64'h0000000000000005, 4'd0, 1);
    vt[8]  = mk(1, 0, 5,  80'h7FFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 4'd0, 1);
    vt[9]  = mk(1, 0, 5,  80'h4080808080, 0, 64'hFFFFFFFFFFFFFFFF, 4'd2, 0);
    vt[10] = mk(1, 1, 10, 80'h7F808080808080808080, 1, 64'h8000000000000000, 4'd0, 1);
    vt[11] = mk(0, 1, 10, 80'h01FFFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 4'd0, 1);
    vt[12] = mk(0, 1, 10, 80'h02808080808080808080, 0, 64'hFFFFFFFFFFFFFFFF, 4'd2, 0);
    vt[13] = mk(1, 0, 1,  80'h40, 0, 64'hFFFFFFFFFFFFFFC0, 4'd0, 1);

    reset          = 1'b0;
    start          = 1'b0;
    signed_mode    = 1'b0;
    width64        = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset value", value, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    chk("reset trap", {60'd0, trap}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i], i);
    end

    // start held through ACCUM and DONE must not restart or extend the decode.
    do_start(0, 1);
    start          = 1'b1;
    bus.byte_in    = 8'h81;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_in    = 8'h01;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("start in accum done", {63'd0, done}, 64'd1);
    chk("start in accum value", value, 64'h0000000000000081);
    @(negedge clk);
    start = 1'b0;
    chk("start in done busy", {63'd0, busy}, 64'd0);
    chk("start in done byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    @(negedge clk);

    // Reset mid-decode.
    do_start(0, 1);
    bus.byte_in    = 8'h80;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset value", value, 64'd0);
    chk("midreset done", {63'd0, done}, 64'd0);
    chk("midreset busy", {63'd0, busy}, 64'd0);
    chk("midreset byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    chk("midreset trap", {60'd0, trap}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_vec(mk(0, 1, 1, 80'h2A, 0, 64'h000000000000002A, 4'd0, 1), 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
